// File: rtl/rob_alloc.sv
// rob_alloc: dispatch-side ROB entry allocator. Hands out up to two
// consecutive tags per cycle, reclaims entries on commit and rolls the
// allocation pointer back to the commit pointer on flush.
module rob_alloc #(
    parameter int ROB_NUM = 64,
    parameter int ROB_SEL = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dp1_req_i,
    input  logic               dp2_req_i,
    input  logic [1:0]         com_cnt_i,
    input  logic               flush_i,
    output logic [ROB_SEL-1:0] dp1_addr_o,
    output logic [ROB_SEL-1:0] dp2_addr_o,
    output logic               alloc_stall_o,
    output logic [ROB_SEL:0]   freenum_o,
    output logic [ROB_SEL-1:0] alloc_ptr_o,
    output logic [ROB_SEL-1:0] commit_ptr_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam logic [ROB_SEL:0]   FULL_CNT = ROB_NUM[ROB_SEL:0];
    localparam logic [ROB_SEL+1:0] FULL_EXT = ROB_NUM[ROB_SEL+1:0];

    logic [ROB_SEL-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [ROB_SEL-1:0] commit_ptr_q, commit_ptr_d;
    logic [ROB_SEL:0]   freenum_q, freenum_d;
    logic [ROB_SEL:0]   req;
    logic [ROB_SEL:0]   alloc;
    logic [ROB_SEL+1:0] free_sum;
    logic [ROB_SEL:0]   occupied;

    // Stall depends only on the registered free count and the request mask,
    // keeping commit/flush off the dispatch-stall critical path.
    always_comb begin
        req           = (ROB_SEL+1)'(dp1_req_i) + (ROB_SEL+1)'(dp2_req_i);
        alloc_stall_o = (req > freenum_q);
        alloc         = (alloc_stall_o || flush_i) ? '0 : req;
    end

    // Next-state: commits always advance; flush snaps alloc_ptr onto the
    // post-commit commit_ptr. Free count saturates on over-commit.
    always_comb begin
        commit_ptr_d = commit_ptr_q + ROB_SEL'(com_cnt_i);
        free_sum     = (ROB_SEL+2)'(freenum_q) - (ROB_SEL+2)'(alloc)
                     + (ROB_SEL+2)'(com_cnt_i);
        alloc_ptr_d  = alloc_ptr_q + ROB_SEL'(alloc);
        freenum_d    = (free_sum > FULL_EXT) ? FULL_CNT : free_sum[ROB_SEL:0];
        if (flush_i) begin
            alloc_ptr_d = commit_ptr_d;
            freenum_d   = FULL_CNT;
        end
    end

    // Pointer and free-count registers, async active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr_q  <= '0;
            commit_ptr_q <= '0;
            freenum_q    <= FULL_CNT;
        end else begin
            alloc_ptr_q  <= alloc_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            freenum_q    <= freenum_d;
        end
    end

    // Flag committing more entries than are in flight.
    assign occupied = FULL_CNT - freenum_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((ROB_SEL+1)'(com_cnt_i) <= occupied)
                else $error("rob_alloc: commit of %0d exceeds occupied %0d",
                            com_cnt_i, occupied);
        end
    end

    // Tags are offered every cycle straight from the allocation pointer.
    always_comb begin
        dp1_addr_o   = alloc_ptr_q;
        dp2_addr_o   = alloc_ptr_q + ROB_SEL'(1);
        freenum_o    = freenum_q;
        alloc_ptr_o  = alloc_ptr_q;
        commit_ptr_o = commit_ptr_q;
        empty_o      = (freenum_q == FULL_CNT);
        full_o       = (freenum_q == '0);
    end

endmodule

// File: tb/tb_rob_alloc.sv
// Directed testbench for rob_alloc: reset, single/dual allocation, fill and
// wrap, commit under full, partial-stall, flush rollback, async reset.
module tb_rob_alloc;

    logic       clk = 1'b0;
    logic       reset;
    logic       dp1_req_i, dp2_req_i, flush_i;
    logic [1:0] com_cnt_i;
    logic [5:0] dp1_addr_o, dp2_addr_o, alloc_ptr_o, commit_ptr_o;
    logic [6:0] freenum_o;
    logic       alloc_stall_o, empty_o, full_o;

    int checks = 0;
    int errors = 0;

    rob_alloc #(.ROB_NUM(64), .ROB_SEL(6)) dut (
        .clk(clk), .reset(reset),
        .dp1_req_i(dp1_req_i), .dp2_req_i(dp2_req_i),
        .com_cnt_i(com_cnt_i), .flush_i(flush_i),
        .dp1_addr_o(dp1_addr_o), .dp2_addr_o(dp2_addr_o),
        .alloc_stall_o(alloc_stall_o), .freenum_o(freenum_o),
        .alloc_ptr_o(alloc_ptr_o), .commit_ptr_o(commit_ptr_o),
        .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dp1_req_i = 0; dp2_req_i = 0; com_cnt_i = 0; flush_i = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dp1_addr_o !== 6'd0) begin errors++; $display("FAIL reset_dp1 got %0d exp 0", dp1_addr_o); end
        checks++; if (dp2_addr_o !== 6'd1) begin errors++; $display("FAIL reset_dp2 got %0d exp 1", dp2_addr_o); end
        checks++; if (alloc_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", alloc_stall_o); end
        checks++; if (freenum_o !== 7'd64) begin errors++; $display("FAIL reset_free got %0d exp 64", freenum_o); end
        checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL reset_flags got e%0b f%0b exp e1 f0", empty_o, full_o); end
        checks++; if (alloc_ptr_o !== 6'd0 || commit_ptr_o !== 6'd0) begin errors++; $display("FAIL reset_ptrs got a%0d c%0d exp 0 0", alloc_ptr_o, commit_ptr_o); end
    endtask

    task automatic test_single();
        do_reset();
        dp1_req_i = 1;
        #1;
        checks++; if (dp1_addr_o !== 6'd0 || alloc_stall_o !== 1'b0) begin errors++; $display("FAIL single_req got tag %0d stall %0b exp 0 0", dp1_addr_o, alloc_stall_o); end
        tick();
        idle();
        checks++; if (alloc_ptr_o !== 6'd1) begin errors++; $display("FAIL single_aptr got %0d exp 1", alloc_ptr_o); end
        checks++; if (freenum_o !== 7'd63) begin errors++; $display("FAIL single_free got %0d exp 63", freenum_o); end
        checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL single_empty got %0b exp 0", empty_o); end
    endtask

    // Fill the ROB with 32 dual requests, then probe the full stall.
    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            dp1_req_i = 1; dp2_req_i = 1;
            #1;
            checks++;
            if (dp1_addr_o !== 6'(2*i) || dp2_addr_o !== 6'(2*i+1) || alloc_stall_o !== 1'b0) begin
                errors++; $display("FAIL fill_tags[%0d] got %0d/%0d stall %0b exp %0d/%0d 0", i, dp1_addr_o, dp2_addr_o, alloc_stall_o, 2*i, 2*i+1);
            end
            tick();
        end
        idle();
        checks++; if (freenum_o !== 7'd0 || full_o !== 1'b1) begin errors++; $display("FAIL fill_full got free %0d full %0b exp 0 1", freenum_o, full_o); end
        checks++; if (alloc_ptr_o !== 6'd0) begin errors++; $display("FAIL fill_wrap got %0d exp 0", alloc_ptr_o); end
        dp1_req_i = 1;
        #1;
        checks++; if (alloc_stall_o !== 1'b1) begin errors++; $display("FAIL full_stall got %0b exp 1", alloc_stall_o); end
        tick();
        idle();
        checks++; if (freenum_o !== 7'd0 || alloc_ptr_o !== 6'd0) begin errors++; $display("FAIL full_hold got free %0d aptr %0d exp 0 0", freenum_o, alloc_ptr_o); end
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_commit_full();
        dp1_req_i = 1; dp2_req_i = 1; com_cnt_i = 2;
        #1;
        checks++; if (alloc_stall_o !== 1'b1) begin errors++; $display("FAIL cf_stall got %0b exp 1", alloc_stall_o); end
        tick();
        com_cnt_i = 0;
        #1;
        checks++; if (freenum_o !== 7'd2 || commit_ptr_o !== 6'd2) begin errors++; $display("FAIL cf_commit got free %0d cptr %0d exp 2 2", freenum_o, commit_ptr_o); end
        checks++; if (dp1_addr_o !== 6'd0 || dp2_addr_o !== 6'd1 || alloc_stall_o !== 1'b0) begin errors++; $display("FAIL cf_tags got %0d/%0d stall %0b exp 0/1 0", dp1_addr_o, dp2_addr_o, alloc_stall_o); end
        tick();
        idle();
        checks++; if (freenum_o !== 7'd0 || alloc_ptr_o !== 6'd2) begin errors++; $display("FAIL cf_realloc got free %0d aptr %0d exp 0 2", freenum_o, alloc_ptr_o); end
    endtask

    // freenum = 1: dual request must stall whole, single request succeeds.
    task automatic test_partial();
        com_cnt_i = 1;
        tick();
        idle();
        checks++; if (freenum_o !== 7'd1 || commit_ptr_o !== 6'd3) begin errors++; $display("FAIL part_setup got free %0d cptr %0d exp 1 3", freenum_o, commit_ptr_o); end
        dp1_req_i = 1; dp2_req_i = 1;
        #1;
        checks++; if (alloc_stall_o !== 1'b1) begin errors++; $display("FAIL part_stall got %0b exp 1", alloc_stall_o); end
        tick();
        checks++; if (freenum_o !== 7'd1 || alloc_ptr_o !== 6'd2) begin errors++; $display("FAIL part_noalloc got free %0d aptr %0d exp 1 2", freenum_o, alloc_ptr_o); end
        dp2_req_i = 0;
        #1;
        checks++; if (dp1_addr_o !== 6'd2 || alloc_stall_o !== 1'b0) begin errors++; $display("FAIL part_single got tag %0d stall %0b exp 2 0", dp1_addr_o, alloc_stall_o); end
        tick();
        idle();
        checks++; if (freenum_o !== 7'd0 || alloc_ptr_o !== 6'd3) begin errors++; $display("FAIL part_after got free %0d aptr %0d exp 0 3", freenum_o, alloc_ptr_o); end
    endtask

    // Allocation and commit in the same cycle both apply.
    task automatic test_churn();
        com_cnt_i = 2;
        tick();
        dp1_req_i = 1; dp2_req_i = 1; com_cnt_i = 2;
        #1;
        checks++; if (dp1_addr_o !== 6'd3 || dp2_addr_o !== 6'd4 || alloc_stall_o !== 1'b0) begin errors++; $display("FAIL churn_tags got %0d/%0d stall %0b exp 3/4 0", dp1_addr_o, dp2_addr_o, alloc_stall_o); end
        tick();
        idle();
        checks++; if (freenum_o !== 7'd2 || alloc_ptr_o !== 6'd5 || commit_ptr_o !== 6'd7) begin errors++; $display("FAIL churn_state got free %0d aptr %0d cptr %0d exp 2 5 7", freenum_o, alloc_ptr_o, commit_ptr_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            dp1_req_i = 1; dp2_req_i = 1;
            tick();
        end
        idle();
        com_cnt_i = 2; tick(); tick();
        idle();
        checks++; if (alloc_ptr_o !== 6'd10 || commit_ptr_o !== 6'd4 || freenum_o !== 7'd58) begin errors++; $display("FAIL flush_setup got aptr %0d cptr %0d free %0d exp 10 4 58", alloc_ptr_o, commit_ptr_o, freenum_o); end
        flush_i = 1; com_cnt_i = 1; dp1_req_i = 1;
        tick();
        idle();
        checks++; if (commit_ptr_o !== 6'd5 || alloc_ptr_o !== 6'd5) begin errors++; $display("FAIL flush_ptrs got cptr %0d aptr %0d exp 5 5", commit_ptr_o, alloc_ptr_o); end
        checks++; if (freenum_o !== 7'd64 || empty_o !== 1'b1) begin errors++; $display("FAIL flush_free got free %0d empty %0b exp 64 1", freenum_o, empty_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            dp1_req_i = 1; dp2_req_i = 1;
            tick();
        end
        dp2_req_i = 0;
        tick();
        idle();
        checks++; if (alloc_ptr_o !== 6'd37) begin errors++; $display("FAIL ar_setup got %0d exp 37", alloc_ptr_o); end
        #2;
        reset = 1;
        #1;
        checks++; if (alloc_ptr_o !== 6'd0 || dp1_addr_o !== 6'd0 || dp2_addr_o !== 6'd1) begin errors++; $display("FAIL ar_ptr got aptr %0d tags %0d/%0d exp 0 0/1", alloc_ptr_o, dp1_addr_o, dp2_addr_o); end
        checks++; if (freenum_o !== 7'd64 || empty_o !== 1'b1 || full_o !== 1'b0 || commit_ptr_o !== 6'd0) begin errors++; $display("FAIL ar_state got free %0d e%0b f%0b cptr %0d exp 64 1 0 0", freenum_o, empty_o, full_o, commit_ptr_o); end
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_single();
        test_fill();
        test_commit_full();
        test_partial();
        test_churn();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
